// File: rtl/router_pkg.sv
// router_pkg: shared header field positions, limits and reader FSM states.
// No ports; imported by the destination reader, its timer and its interface users.
package router_pkg;
    localparam int LEN_MSB = 7;
    localparam int LEN_LSB = 2;
    localparam int ADDR_MSB = 1;
    localparam int ADDR_LSB = 0;
    localparam int MAX_LEN = 63;
    localparam int SOFT_RST_TIMEOUT = 30;
    typedef enum logic [2:0] {IDLE, WAIT, HDR, BODY, DONE} state_t;
    // Reads needed after the header: payload plus parity, with an empty payload read as one byte.
    function automatic logic [6:0] read_count(input logic [5:0] len);
        return (len == '0 ? 7'd1 : {1'b0, len}) + 7'd1;
    endfunction
endpackage

// File: rtl/router_dst_reader_if.sv
// router_dst_reader_if: output-port FIFO handshake plus framed byte stream of one destination reader.
// slave: the reader (consumes vld_out/data_out/soft_reset, drives read_enb and the framed stream).
// master: the FIFO/sync side and stream consumer.
interface router_dst_reader_if;
    logic vld_out;
    logic [7:0] data_out;
    logic soft_reset;
    logic read_enb;
    logic [7:0] pkt_byte;
    logic pkt_valid;
    logic pkt_sop;
    logic pkt_eop;
    logic pkt_done;
    logic parity_err;
    logic addr_err;
    logic pkt_abort;
    logic [5:0] len_out;
    logic busy;
    modport master (
        output vld_out, data_out, soft_reset,
        input read_enb, pkt_byte, pkt_valid, pkt_sop, pkt_eop, pkt_done,
        input parity_err, addr_err, pkt_abort, len_out, busy
    );
    modport slave (
        input vld_out, data_out, soft_reset,
        output read_enb, pkt_byte, pkt_valid, pkt_sop, pkt_eop, pkt_done,
        output parity_err, addr_err, pkt_abort, len_out, busy
    );
endinterface

// File: rtl/router_rd_timer.sv
// router_rd_timer: WAIT delay counter; start loads 1, run increments, otherwise clears.
// Ports: clock, resetn (async active-low), start, run, hit (count == READ_DELAY).
module router_rd_timer #(
    parameter int READ_DELAY = 5
) (
    input  logic clock,
    input  logic resetn,
    input  logic start,
    input  logic run,
    output logic hit
);
    logic [7:0] count;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) count <= '0;
        else count <= start ? 8'd1 : run ? count + 8'd1 : '0;
    end

    assign hit = count == 8'(READ_DELAY);
endmodule

// File: rtl/router_dst_reader.sv
// router_dst_reader: drains one packet per transaction from a router output FIFO and frames it.
// Ports: clock, resetn (async active-low), bus (router_dst_reader_if.slave: FIFO handshake in,
// read_enb out, framed byte stream with sop/eop, done/error/abort pulses, len_out, busy).
module router_dst_reader
    import router_pkg::*;
#(
    parameter int READ_DELAY = 5,
    parameter logic [1:0] PORT_ID = 2'd0
) (
    input logic clock,
    input logic resetn,
    router_dst_reader_if.slave bus
);
    state_t state;
    logic hdr_rd;
    logic rd_q;
    logic [6:0] rem;
    logic [7:0] acc;
    logic perr;
    logic aerr;
    logic [5:0] len_q;
    logic abort_q;
    logic hit;
    logic rd;
    logic cap;
    logic last;

    router_rd_timer #(.READ_DELAY(READ_DELAY)) u_timer (
        .clock(clock),
        .resetn(resetn),
        .start(state == IDLE && bus.vld_out && !bus.soft_reset),
        .run(state == WAIT),
        .hit(hit)
    );

    // Soft reset gates the strobe and any capture in the same cycle it is seen.
    assign rd = !bus.soft_reset && (hdr_rd || (state == BODY && bus.vld_out && rem != '0));
    assign cap = rd_q && !bus.soft_reset && (state == HDR || state == BODY);
    // Once every read has been issued, the capture still in flight is the parity byte.
    assign last = cap && state == BODY && rem == '0;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            hdr_rd <= 1'b0;
            rd_q <= 1'b0;
            rem <= '0;
            acc <= '0;
            perr <= 1'b0;
            aerr <= 1'b0;
            len_q <= '0;
            abort_q <= 1'b0;
        end else begin
            rd_q <= rd;
            hdr_rd <= 1'b0;
            abort_q <= 1'b0;
            if (bus.soft_reset && state != IDLE) begin
                state <= IDLE;
                rem <= '0;
                abort_q <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (bus.vld_out && !bus.soft_reset) state <= WAIT;
                    WAIT: begin
                        if (!bus.vld_out) state <= IDLE;
                        else if (hit) begin
                            hdr_rd <= 1'b1;
                            state <= HDR;
                        end
                    end
                    HDR: if (cap) begin
                        len_q <= bus.data_out[LEN_MSB:LEN_LSB];
                        rem <= read_count(bus.data_out[LEN_MSB:LEN_LSB]);
                        acc <= bus.data_out;
                        aerr <= bus.data_out[ADDR_MSB:ADDR_LSB] != PORT_ID || bus.data_out[LEN_MSB:LEN_LSB] == '0;
                        state <= BODY;
                    end
                    BODY: begin
                        if (rd) rem <= rem - 7'd1;
                        if (last) begin
                            perr <= bus.data_out != acc;
                            state <= DONE;
                        end else if (cap) acc <= acc ^ bus.data_out;
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.read_enb = rd;
    assign bus.pkt_valid = cap;
    assign bus.pkt_byte = cap ? bus.data_out : '0;
    assign bus.pkt_sop = cap && state == HDR;
    assign bus.pkt_eop = last;
    assign bus.pkt_done = state == DONE && !bus.soft_reset;
    assign bus.parity_err = bus.pkt_done && perr;
    assign bus.addr_err = bus.pkt_done && aerr;
    assign bus.pkt_abort = abort_q;
    assign bus.len_out = len_q;
    assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_router_dst_reader.sv
// tb_router_dst_reader: FIFO responder, packet-level scoreboard and directed scenarios for the reader.
module tb_router_dst_reader;
    localparam logic [1:0] PID = 2'd0;

    typedef struct packed {
        logic [7:0] b;
        logic sop;
        logic eop;
    } beat_t;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic stall = 1'b0;
    logic flush = 1'b0;
    logic [7:0] fifo [0:1023];
    logic [7:0] pl [0:63];
    int wp = 0;
    int rp = 0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int beats_seen = 0;
    int done_cnt = 0;
    int c0, t_rd, t_done, b0, d0;
    beat_t exp_b[$];
    logic [1:0] exp_d[$];

    always #5 clock = ~clock;

    router_dst_reader_if bus();

    router_dst_reader #(.READ_DELAY(5), .PORT_ID(PID)) dut (
        .clock(clock),
        .resetn(resetn),
        .bus(bus)
    );

    // FIFO responder: data valid the cycle after read_enb is sampled.
    assign bus.vld_out = (wp != rp) && !stall;
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (flush) rp <= wp;
        else if (bus.read_enb) begin
            bus.data_out <= fifo[rp];
            rp <= rp + 1;
        end
    end

    function automatic logic [21:0] outs();
        return {bus.read_enb, bus.pkt_byte, bus.pkt_valid, bus.pkt_sop, bus.pkt_eop, bus.pkt_done,
                bus.parity_err, bus.addr_err, bus.pkt_abort, bus.len_out, bus.busy};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Packet model: expected framed beats and done flags derived from the packet bytes.
    task automatic push_pkt(input logic [7:0] hdr, input int n, input logic [7:0] par);
        logic [7:0] x;
        x = hdr;
        fifo[wp] = hdr;
        exp_b.push_back({hdr, 1'b1, 1'b0});
        for (int i = 0; i < n; i++) begin
            fifo[wp + 1 + i] = pl[i];
            exp_b.push_back({pl[i], 1'b0, 1'b0});
            x = x ^ pl[i];
        end
        fifo[wp + 1 + n] = par;
        exp_b.push_back({par, 1'b0, 1'b1});
        exp_d.push_back({x != par, hdr[1:0] != PID || hdr[7:2] == 6'd0});
        wp = wp + n + 2;
    endtask

    task automatic compare_loop();
        beat_t e;
        logic [1:0] d;
        forever begin
            @(negedge clock);
            if (resetn) begin
                if (bus.pkt_valid) begin
                    beats_seen++;
                    if (exp_b.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL beat_extra: got byte %0h, required no beat", bus.pkt_byte);
                    end else begin
                        e = exp_b.pop_front();
                        chk("beat", {bus.pkt_byte, bus.pkt_sop, bus.pkt_eop}, e);
                    end
                end else chk("frame_idle", {bus.pkt_sop, bus.pkt_eop}, 0);
                if (bus.pkt_done) begin
                    done_cnt++;
                    if (exp_d.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL done_extra: got pkt_done, required none");
                    end else begin
                        d = exp_d.pop_front();
                        chk("done_flags", {bus.parity_err, bus.addr_err}, d);
                    end
                end
            end
        end
    endtask

    task automatic wait_done(output int t);
        t = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (bus.pkt_done) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no pkt_done in 200 cycles, required one");
        end
    endtask

    task automatic settle(input logic [5:0] len);
        @(negedge clock);
        chk("beats_left", exp_b.size(), 0);
        chk("len_out", bus.len_out, len);
        chk("busy_after", bus.busy, 0);
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            #1;
            if (beats_seen - b0 >= n) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.soft_reset = 1'b0;
        fork
            compare_loop();
        join_none
        repeat (3) @(negedge clock);
        chk("reset_outs", outs(), 0);
        resetn = 1'b1;
        @(negedge clock);
        chk("idle_outs", outs(), 0);

        // Basic packet: delay, single header strobe, L+4 packet time, 7 beats.
        for (int i = 0; i < 5; i++) pl[i] = 8'(8'h11 * (i + 1));
        b0 = beats_seen;
        push_pkt(8'h14, 5, 8'h05);
        @(posedge clock);
        #1;
        c0 = cyc;
        chk("busy_wait", bus.busy, 1);
        t_rd = -1000;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (bus.read_enb) begin
                t_rd = cyc;
                break;
            end
        end
        chk("hdr_delay", t_rd - c0, 5);
        @(negedge clock);
        chk("hdr_rd_one_cycle", bus.read_enb, 0);
        wait_done(t_done);
        chk("pkt_time", t_done - t_rd, 9);
        chk("beats_basic", beats_seen - b0, 7);
        chk("perr_basic", bus.parity_err, 0);
        chk("aerr_basic", bus.addr_err, 0);
        settle(6'd5);

        // Bad parity.
        push_pkt(8'h14, 5, 8'h04);
        wait_done(t_done);
        chk("perr_bad", bus.parity_err, 1);
        settle(6'd5);

        // Wrong address: L=3, addr=1.
        for (int i = 0; i < 3; i++) pl[i] = 8'(i + 1);
        b0 = beats_seen;
        push_pkt(8'h0D, 3, 8'h0D);
        wait_done(t_done);
        chk("aerr_addr", bus.addr_err, 1);
        chk("perr_addr", bus.parity_err, 0);
        chk("beats_addr", beats_seen - b0, 5);
        settle(6'd3);

        // Zero length: one payload byte is read, flagged malformed.
        pl[0] = 8'hAA;
        b0 = beats_seen;
        push_pkt(8'h00, 1, 8'hAA);
        wait_done(t_done);
        chk("aerr_len0", bus.addr_err, 1);
        chk("beats_len0", beats_seen - b0, 3);
        settle(6'd0);

        // FIFO stall after payload byte 2.
        for (int i = 0; i < 5; i++) pl[i] = 8'(8'h11 * (i + 1));
        b0 = beats_seen;
        push_pkt(8'h14, 5, 8'h05);
        wait_beats(3);
        stall = 1'b1;
        #1;
        chk("stall_rd0", bus.read_enb, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("stall_rd", bus.read_enb, 0);
        end
        stall = 1'b0;
        #1;
        chk("resume_rd", bus.read_enb, 1);
        wait_done(t_done);
        chk("perr_stall", bus.parity_err, 0);
        chk("beats_stall", beats_seen - b0, 7);
        settle(6'd5);

        // Soft-reset abort after 3 payload bytes.
        b0 = beats_seen;
        push_pkt(8'h14, 5, 8'h05);
        wait_beats(4);
        @(posedge clock);
        #1;
        chk("rd_before_abort", bus.read_enb, 1);
        bus.soft_reset = 1'b1;
        flush = 1'b1;
        exp_b.delete();
        exp_d.delete();
        d0 = done_cnt;
        #1;
        chk("abort_rd", bus.read_enb, 0);
        chk("abort_valid", bus.pkt_valid, 0);
        @(posedge clock);
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_pulse", bus.pkt_abort, 1);
        bus.soft_reset = 1'b0;
        flush = 1'b0;
        @(posedge clock);
        #1;
        chk("abort_pulse_end", bus.pkt_abort, 0);
        repeat (20) @(negedge clock);
        chk("abort_no_done", done_cnt - d0, 0);

        // Recovery after abort.
        push_pkt(8'h14, 5, 8'h05);
        wait_done(t_done);
        chk("perr_recover", bus.parity_err, 0);
        settle(6'd5);

        // Asynchronous reset mid-packet.
        b0 = beats_seen;
        push_pkt(8'h14, 5, 8'h05);
        wait_beats(3);
        #1;
        resetn = 1'b0;
        #1;
        chk("async_outs", outs(), 0);
        exp_b.delete();
        exp_d.delete();
        flush = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        flush = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        chk("post_reset_outs", outs(), 0);

        // Final clean packet: L=2.
        pl[0] = 8'h5A;
        pl[1] = 8'hA5;
        b0 = beats_seen;
        push_pkt(8'h08, 2, 8'hF7);
        wait_done(t_done);
        chk("perr_final", bus.parity_err, 0);
        chk("beats_final", beats_seen - b0, 4);
        settle(6'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/router_dst_reader.md
# router_dst_reader

Destination-side consumer for one router output port. It watches the port's `vld_out` and issues `read_enb` within a bounded delay, so the sync block's 30-cycle soft-reset timer never expires in normal use. It drains one complete packet per transaction (header, payload, parity) and presents the bytes on a framed streaming output with parity and address checks. One instance sits on each of the three output FIFOs; it serves as both the bench's responder model and the synthesizable sink for the SoC integration.

## Interface
- `READ_DELAY`, 5: cycles from first sampled `vld_out` to header `read_enb`; legal 1..29.
- `PORT_ID`, 2'd0: expected destination address of packets on this port.
- `clock` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `vld_out` in 1: port FIFO non-empty.
- `data_out` in 8: FIFO read data, valid the cycle after `read_enb` is sampled high.
- `soft_reset` in 1: port soft reset from the sync block; aborts the current packet.
- `read_enb` out 1: FIFO read strobe.
- `pkt_byte` out 8: captured byte.
- `pkt_valid` out 1: `pkt_byte` valid this cycle.
- `pkt_sop` out 1: with `pkt_valid`, marks the header byte.
- `pkt_eop` out 1: with `pkt_valid`, marks the parity byte.
- `pkt_done` out 1: one-cycle pulse after the parity byte.
- `parity_err` out 1: qualified by `pkt_done`.
- `addr_err` out 1: qualified by `pkt_done`; set when header[1:0] != `PORT_ID`.
- `pkt_abort` out 1: one-cycle pulse on a `soft_reset` abort.
- `len_out` out 6: payload length of the last header, held until the next header.
- `busy` out 1: FSM not in IDLE.

## Operation
- Packet format: header [7:2] = payload length L (1..63), header [1:0] = address. Then L payload bytes. Then the parity byte, which is the XOR of the header and all payload bytes.
- **IDLE**:
  - `vld_out`=1 sampled → WAIT with delay count = 1.
- **WAIT**:
  - Count increments each cycle.
  - At count == `READ_DELAY` with `vld_out`=1: assert `read_enb` for exactly one cycle, then go to HDR.
  - If `vld_out` drops during WAIT → IDLE.
- **HDR**:
  - Header byte is captured; `pkt_valid`=`pkt_sop`=1.
  - L is latched into `len_out`.
  - Remaining-reads counter is loaded with L+1; parity accumulator is initialised with the header.
  - Go to BODY.
- **BODY**:
  - `read_enb` = `vld_out` && (remaining reads > 0); it is combinational on `vld_out` and registered state.
  - Each sampled read decrements the counter.
  - Each captured byte is output with `pkt_valid`=1 and XORed into the accumulator.
  - The capture that is the (L+1)th in BODY is the parity byte: `pkt_eop`=1, and the byte is compared with the accumulator (excluding itself). Then go to DONE.
- **DONE**:
  - `pkt_done`=1 with `parity_err` and `addr_err` for one cycle.
  - Go to IDLE. A new packet may start WAIT on the next sample of `vld_out`.
- **Capture flag**: `rd_q` is `read_enb` delayed by one register. A capture happens exactly when `rd_q`=1.
- **Length zero**: L = 0 is treated as L = 1 for the read count and flagged via `addr_err`=1 (malformed).
- **Soft reset**: `soft_reset`=1 in any non-IDLE state:
  - forces IDLE next cycle;
  - `pkt_abort` pulses;
  - `read_enb` is deasserted the same cycle (combinational gate);
  - the pending capture is discarded and no `pkt_done` is issued.
- **FIFO stall**: `vld_out` low in BODY pauses reads indefinitely with no timeout.

## Timing
- Reset values: all outputs 0, `len_out`=0, FSM in IDLE, counters 0.
- Reset is asynchronous assert and synchronous deassert (synchronised externally).
- Header `read_enb` is asserted `READ_DELAY` cycles after the edge that first samples `vld_out`=1.
- Byte latency: `pkt_valid` is asserted one cycle after the corresponding `read_enb`.
- With continuous `vld_out`, the minimum packet time from header `read_enb` to `pkt_done` is L+4 cycles.
- Back-to-back packets: IDLE→WAIT takes at least one cycle after DONE.

## Structure
- Shared `router_pkg`:
  - header field positions (LEN_MSB=7, LEN_LSB=2, ADDR_MSB=1, ADDR_LSB=0);
  - MAX_LEN=63;
  - SOFT_RST_TIMEOUT=30;
  - state enum {IDLE, WAIT, HDR, BODY, DONE}.
- Sub-module `router_rd_timer`: the WAIT delay counter with its compare and clear. It is reused by the bench's misbehaving-reader model when `READ_DELAY` ≥ 30.

## Test plan
- **Basic packet**:
  - Stimulus: `READ_DELAY`=5, `PORT_ID`=0; packet 0x14, 0x11, 0x22, 0x33, 0x44, 0x55, parity 0x05.
  - Response: `read_enb` is asserted 5 cycles after `vld_out`; 7 `pkt_valid` beats with `pkt_sop` on 0x14 and `pkt_eop` on 0x05; `pkt_done` with `parity_err`=0, `addr_err`=0; `len_out`=5.
- **Bad parity**:
  - Stimulus: same packet with parity byte 0x04.
  - Response: `pkt_done` with `parity_err`=1.
- **Wrong address**:
  - Stimulus: header 0x0D (L=3, addr=1) on a `PORT_ID`=0 instance.
  - Response: `addr_err`=1 at `pkt_done`; all 5 bytes are still delivered.
- **FIFO stall**:
  - Stimulus: `vld_out` low for 10 cycles after payload byte 2.
  - Response: `read_enb` stays 0 during the gap and resumes on its release; the byte sequence is intact; `parity_err`=0.
- **Soft-reset abort**:
  - Stimulus: `soft_reset`=1 in BODY after 3 payload bytes.
  - Response: `read_enb` drops the same cycle; `pkt_abort` pulses; no `pkt_done`; `busy`=0 the next cycle.
- **Async reset mid-packet**:
  - Stimulus: `resetn`=0 mid-packet.
  - Response: all outputs read 0 immediately, without waiting for a clock edge.
